// File: rtl/keypad_guess_buffer.sv
// Keypad guess buffer: turns the decoder's held key code into one event per
// physical press (stability filter plus release requirement), collects decimal
// digits into a fixed-length guess and commits it on the enter button.
module keypad_guess_buffer #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 100000,
  parameter int CNT_W         = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          key_code,
  input  logic                key_down,
  input  logic                btn_del,
  input  logic                btn_enter,
  output logic [4*DIGITS-1:0] buf_digits,
  output logic [3:0]          buf_count,
  output logic [4*DIGITS-1:0] guess,
  output logic                guess_valid,
  output logic                reject
);

  typedef enum logic [1:0] {
    IDLE,
    STABLE,
    HELD
  } key_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       COUNT_FULL = 4'(DIGITS);

  key_state_t          state;
  key_state_t          state_nxt;
  logic [3:0]          cand;
  logic [CNT_W-1:0]    cnt;
  logic                key_match;
  logic                key_evt;
  logic                del_prev;
  logic                enter_prev;
  logic                del_rise;
  logic                enter_rise;
  logic [4*DIGITS-1:0] buf_digits_nxt;
  logic [3:0]          buf_count_nxt;
  logic [4*DIGITS-1:0] guess_nxt;
  logic                guess_valid_nxt;
  logic                reject_nxt;

  assign key_match  = key_down && (key_code == cand);
  assign del_rise   = btn_del & ~del_prev;
  assign enter_rise = btn_enter & ~enter_prev;

  // Previous button levels, so each press produces a single rising-edge action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      del_prev   <= 1'b0;
      enter_prev <= 1'b0;
    end else begin
      del_prev   <= btn_del;
      enter_prev <= btn_enter;
    end
  end

  // Key filter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Key filter next state: a code must stay steady to reach HELD, and a full release is needed to re-arm.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (key_down) state_nxt = STABLE;
      end
      STABLE: begin
        if (!key_match)           state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = HELD;
      end
      HELD: begin
        if (!key_down) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key filter output: one event on the cycle the steady count completes.
  always_comb begin
    key_evt = (state == STABLE) && key_match && (cnt == CNT_LAST);
  end

  // Candidate code capture and stability counter; a fresh press always restarts the count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= 4'd0;
      cnt  <= '0;
    end else if (state == IDLE && key_down) begin
      cand <= key_code;
      cnt  <= '0;
    end else if (state == STABLE && key_match && cnt != CNT_LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Action arbitration: enter beats delete beats key, losers in the same cycle are simply dropped.
  always_comb begin
    buf_digits_nxt  = buf_digits;
    buf_count_nxt   = buf_count;
    guess_nxt       = guess;
    guess_valid_nxt = 1'b0;
    reject_nxt      = 1'b0;
    if (enter_rise) begin
      if (buf_count == COUNT_FULL) begin
        guess_nxt       = buf_digits;
        guess_valid_nxt = 1'b1;
        buf_digits_nxt  = '0;
        buf_count_nxt   = 4'd0;
      end else begin
        reject_nxt = 1'b1;
      end
    end else if (del_rise) begin
      if (buf_count != 4'd0) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (4'(i) == buf_count - 4'd1) buf_digits_nxt[4*(DIGITS-1-i) +: 4] = 4'd0;
        end
        buf_count_nxt = buf_count - 4'd1;
      end else begin
        reject_nxt = 1'b1;
      end
    end else if (key_evt) begin
      if (cand > 4'd9) begin
        buf_count_nxt = buf_count;
      end else if (buf_count < COUNT_FULL) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (4'(i) == buf_count) buf_digits_nxt[4*(DIGITS-1-i) +: 4] = cand;
        end
        buf_count_nxt = buf_count + 4'd1;
      end else begin
        reject_nxt = 1'b1;
      end
    end
  end

  // Registered outputs; the two strobes fall back to zero on any cycle without an action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_digits  <= '0;
      buf_count   <= 4'd0;
      guess       <= '0;
      guess_valid <= 1'b0;
      reject      <= 1'b0;
    end else begin
      buf_digits  <= buf_digits_nxt;
      buf_count   <= buf_count_nxt;
      guess       <= guess_nxt;
      guess_valid <= guess_valid_nxt;
      reject      <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_guess_buffer.sv
// Self-checking bench for keypad_guess_buffer: a table of key/delete/enter
// actions with expected buffer contents, a pulse scoreboard, and hand-written
// sequences for filter latency, glitches, collisions and mid-press reset.
module tb_keypad_guess_buffer;

  localparam int DIGITS = 4;
  localparam int STABLE = 8;
  localparam int CNT_W  = 4;

  localparam logic [1:0] A_KEY   = 2'd0;
  localparam logic [1:0] A_DEL   = 2'd1;
  localparam logic [1:0] A_ENTER = 2'd2;

  localparam logic [1:0] P_NONE   = 2'd0;
  localparam logic [1:0] P_VALID  = 2'd1;
  localparam logic [1:0] P_REJECT = 2'd2;

  typedef struct {
    logic [1:0]  action;
    logic [3:0]  code;
    logic [1:0]  pulse;
    logic [15:0] exp_digits;
    logic [3:0]  exp_count;
    logic [15:0] exp_guess;
  } vec_t;

  typedef struct {
    logic        is_reject;
    logic [15:0] guess;
  } pulse_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_down;
  logic        btn_del;
  logic        btn_enter;
  logic [15:0] buf_digits;
  logic [3:0]  buf_count;
  logic [15:0] guess;
  logic        guess_valid;
  logic        reject;

  int     tests;
  int     fails;
  pulse_t exp_q[$];
  pulse_t mon_exp;
  vec_t   vecs[18];

  keypad_guess_buffer #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_down   (key_down),
    .btn_del    (btn_del),
    .btn_enter  (btn_enter),
    .buf_digits (buf_digits),
    .buf_count  (buf_count),
    .guess      (guess),
    .guess_valid(guess_valid),
    .reject     (reject)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse monitor: every strobe cycle must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && (guess_valid || reject)) begin
      tests++;
      if (guess_valid && reject) begin
        fails++;
        $display("[TB] FAIL pulse_overlap: guess_valid=1 reject=1, required at most one");
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_pulse: guess_valid=%0b reject=%0b, required none", guess_valid, reject);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp.is_reject != reject || (!mon_exp.is_reject && guess != mon_exp.guess)) begin
          fails++;
          $display("[TB] FAIL pulse_kind: got reject=%0b guess=%h, required reject=%0b guess=%h",
                   reject, guess, mon_exp.is_reject, mon_exp.guess);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input logic [1:0] kind, input logic [15:0] g);
    pulse_t p;
    p.is_reject = (kind == P_REJECT);
    p.guess     = g;
    if (kind != P_NONE) exp_q.push_back(p);
  endtask

  task automatic check_queue_empty(input string name);
    check_val(name, 16'(exp_q.size()), 16'd0);
  endtask

  task automatic press_key(input logic [3:0] code, input int hold);
    key_code = code;
    key_down = 1'b1;
    repeat (hold) step();
    key_down = 1'b0;
    repeat (3) step();
  endtask

  task automatic pulse_button(input logic del, input logic enter);
    btn_del   = del;
    btn_enter = enter;
    step();
    btn_del   = 1'b0;
    btn_enter = 1'b0;
    repeat (3) step();
  endtask

  task automatic apply_stimulus(input vec_t v);
    expect_pulse(v.pulse, v.exp_guess);
    case (v.action)
      A_KEY:   press_key(v.code, 2 * STABLE);
      A_DEL:   pulse_button(1'b1, 1'b0);
      default: pulse_button(1'b0, 1'b1);
    endcase
  endtask

  task automatic check_output(input string name, input logic [15:0] ed, input logic [3:0] ec,
                              input logic [15:0] eg);
    @(negedge clk);
    check_val({name, ".digits"}, buf_digits, ed);
    check_val({name, ".count"}, 16'(buf_count), 16'(ec));
    check_val({name, ".guess"}, guess, eg);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    key_code  = 4'd0;
    key_down  = 1'b0;
    btn_del   = 1'b0;
    btn_enter = 1'b0;

    vecs[0]  = '{A_KEY,   4'h1, P_NONE,   16'h1000, 4'd1, 16'h0000};
    vecs[1]  = '{A_KEY,   4'h2, P_NONE,   16'h1200, 4'd2, 16'h0000};
    vecs[2]  = '{A_KEY,   4'h3, P_NONE,   16'h1230, 4'd3, 16'h0000};
    vecs[3]  = '{A_KEY,   4'h4, P_NONE,   16'h1234, 4'd4, 16'h0000};
    vecs[4]  = '{A_KEY,   4'h5, P_REJECT, 16'h1234, 4'd4, 16'h0000};
    vecs[5]  = '{A_DEL,   4'h0, P_NONE,   16'h1230, 4'd3, 16'h0000};
    vecs[6]  = '{A_KEY,   4'h4, P_NONE,   16'h1234, 4'd4, 16'h0000};
    vecs[7]  = '{A_ENTER, 4'h0, P_VALID,  16'h0000, 4'd0, 16'h1234};
    vecs[8]  = '{A_DEL,   4'h0, P_REJECT, 16'h0000, 4'd0, 16'h1234};
    vecs[9]  = '{A_ENTER, 4'h0, P_REJECT, 16'h0000, 4'd0, 16'h1234};
    vecs[10] = '{A_KEY,   4'h9, P_NONE,   16'h9000, 4'd1, 16'h1234};
    vecs[11] = '{A_KEY,   4'h0, P_NONE,   16'h9000, 4'd2, 16'h1234};
    vecs[12] = '{A_KEY,   4'hB, P_NONE,   16'h9000, 4'd2, 16'h1234};
    vecs[13] = '{A_DEL,   4'h0, P_NONE,   16'h9000, 4'd1, 16'h1234};
    vecs[14] = '{A_KEY,   4'h7, P_NONE,   16'h9700, 4'd2, 16'h1234};
    vecs[15] = '{A_KEY,   4'h6, P_NONE,   16'h9760, 4'd3, 16'h1234};
    vecs[16] = '{A_KEY,   4'h8, P_NONE,   16'h9768, 4'd4, 16'h1234};
    vecs[17] = '{A_ENTER, 4'h0, P_VALID,  16'h0000, 4'd0, 16'h9768};

    repeat (3) step();
    check_val("reset.valid_reject", {14'd0, guess_valid, reject}, 16'd0);
    rst_n = 1'b1;
    step();
    check_output("reset", 16'h0000, 4'd0, 16'h0000);

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_count, vecs[i].exp_guess);
    end
    check_queue_empty("table.pending_pulses");

    // Filter latency: the digit lands one cycle after STABLE cycles of steady key_down.
    key_code = 4'h1;
    key_down = 1'b1;
    repeat (STABLE) @(posedge clk);
    @(negedge clk);
    check_val("latency.before", 16'(buf_count), 16'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("latency.after", 16'(buf_count), 16'd1);
    check_val("latency.digits", buf_digits, 16'h1000);
    #1;
    key_down = 1'b0;
    repeat (3) step();

    // Short press and code toggling must never produce an event.
    press_key(4'h7, STABLE - 2);
    key_code = 4'h7;
    key_down = 1'b1;
    repeat (5) step();
    key_code = 4'h8;
    repeat (5) step();
    key_code = 4'h7;
    repeat (5) step();
    key_code = 4'h8;
    repeat (5) step();
    key_down = 1'b0;
    repeat (3) step();
    check_output("glitch", 16'h1000, 4'd1, 16'h9768);

    // A long hold yields exactly one digit.
    press_key(4'h7, 10 * STABLE);
    check_output("long_hold", 16'h1700, 4'd2, 16'h9768);

    // Enter and delete rising together: enter wins and rejects, delete is dropped.
    expect_pulse(P_REJECT, 16'h0);
    pulse_button(1'b1, 1'b1);
    check_output("collision", 16'h1700, 4'd2, 16'h9768);
    check_queue_empty("collision.pending_pulses");

    // Reset while a press is mid-count clears everything at once.
    press_key(4'h2, 2 * STABLE);
    check_output("pre_reset", 16'h1720, 4'd3, 16'h9768);
    key_code = 4'h5;
    key_down = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #2;
    check_val("async_reset.digits", buf_digits, 16'h0000);
    check_val("async_reset.count", 16'(buf_count), 16'd0);
    check_val("async_reset.guess", guess, 16'h0000);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (STABLE) @(posedge clk);
    @(negedge clk);
    check_val("post_reset.before", 16'(buf_count), 16'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("post_reset.after", 16'(buf_count), 16'd1);
    check_val("post_reset.digits", buf_digits, 16'h5000);
    #1;
    key_down = 1'b0;
    repeat (3) step();
    check_queue_empty("final.pending_pulses");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
